// File: rtl/uart_mem_loader_arb_pkg.sv
// Shared types and marker bytes for the UART program loader.
// LOADER_CHECKSUM_EN adds a fifth XOR checksum byte to each frame.
package uart_loader_pkg;

    localparam logic [7:0] START_MARK = 8'h55;
    localparam logic [7:0] STOP_MARK  = 8'hAA;
    localparam logic [7:0] RUN_MARK   = 8'h5A;

`ifdef LOADER_CHECKSUM_EN
    localparam int PAY_BYTES = 5;
`else
    localparam int PAY_BYTES = 4;
`endif

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        WAIT_STOP
    } parser_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        A_L,
        D_L,
        A_U,
        D_U
    } seq_state_e;

    typedef enum logic {
        LOAD,
        RUN
    } mode_e;

    function automatic logic [7:0] csum4(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return b0 ^ b1 ^ b2 ^ b3;
    endfunction

endpackage

// File: rtl/uart_mem_loader_arb_if.sv
// Memory-style bus: shared by the CPU side and the memory side.
interface uart_mem_loader_arb_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] addr_data;
    logic              read_write;
    logic              write_commit;

    modport master (
        output addr_data,
        output read_write,
        output write_commit
    );

    modport slave (
        input addr_data,
        input read_write,
        input write_commit
    );
endinterface

// File: rtl/uart_mem_loader_arb_parser.sv
// Byte-stream frame parser: START, payload, STOP -> addr/data + status strobes.
// LOADER_CHECKSUM_EN expects and verifies a fifth XOR byte.
module loader_frame_parser
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W     = 10,
    parameter int         DATA_W     = 12,
    parameter logic [7:0] START_BYTE = START_MARK,
    parameter logic [7:0] STOP_BYTE  = STOP_MARK,
    parameter logic [7:0] RUN_BYTE   = RUN_MARK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              frame_ok,
    output logic              frame_bad,
    output logic              start_seen,
    output logic              run_req
);

    localparam logic [2:0] LAST = 3'(PAY_BYTES - 1);

    parser_state_e state;
    logic [2:0]    idx;
    logic [7:0]    pay [PAY_BYTES];
    logic          sum_ok;
    logic          is_start;
    logic          is_stop;
    logic          unused_bits;

    assign unused_bits = ^{pay[0][7:2], pay[3][7:4]};

    always_comb begin
        is_start = rx_valid && (rx_data == START_BYTE);
        is_stop  = rx_valid && (rx_data == STOP_BYTE);
        addr     = ADDR_W'({pay[0][1:0], pay[1]});
        data     = DATA_W'({pay[2], pay[3][3:0]});
`ifdef LOADER_CHECKSUM_EN
        sum_ok   = pay[4] == csum4(pay[0], pay[1], pay[2], pay[3]);
`else
        sum_ok   = 1'b1;
`endif
        frame_ok   = is_stop && (state == WAIT_STOP) && sum_ok;
        frame_bad  = (is_stop && (state == PAYLOAD))
                   || (rx_valid && (state == WAIT_STOP)
                       && !(rx_data == STOP_BYTE && sum_ok));
        start_seen = is_start;
        run_req    = rx_valid && (state == IDLE)
                   && (rx_data == RUN_BYTE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < PAY_BYTES; i++) pay[i] <= '0;
        end else if (rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (is_start) begin
                        state <= PAYLOAD;
                        idx   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (is_start) begin
                        idx <= '0;
                    end else if (is_stop) begin
                        state <= IDLE;
                    end else begin
                        for (int i = 0; i < PAY_BYTES; i++)
                            if (idx == 3'(i)) pay[i] <= rx_data;
                        idx <= idx + 3'd1;
                        if (idx == LAST) state <= WAIT_STOP;
                    end
                end
                WAIT_STOP: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_loader_arb.sv
// UART program loader and memory-port owner; mode FSM, write sequencer, mux.
// LOADER_CHECKSUM_EN enables per-frame XOR checksum checking in the parser.
module uart_mem_loader_arb
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W     = 10,
    parameter int         DATA_W     = 12,
    parameter logic [7:0] START_BYTE = START_MARK,
    parameter logic [7:0] STOP_BYTE  = STOP_MARK,
    parameter logic [7:0] RUN_BYTE   = RUN_MARK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    uart_mem_loader_arb_if.slave   cpu,
    uart_mem_loader_arb_if.master  mem,
    output logic                   cpu_rst,
    output logic                   loading,
    output logic [7:0]             frame_count,
    output logic                   frame_err
);

    localparam int HALF = DATA_W / 2;

    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_data;
    logic              frame_ok;
    logic              frame_bad;
    logic              start_seen;
    logic              run_req;

    loader_frame_parser #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .START_BYTE (START_BYTE),
        .STOP_BYTE  (STOP_BYTE),
        .RUN_BYTE   (RUN_BYTE)
    ) u_parser (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr       (p_addr),
        .data       (p_data),
        .frame_ok   (frame_ok),
        .frame_bad  (frame_bad),
        .start_seen (start_seen),
        .run_req    (run_req)
    );

    seq_state_e        seq;
    mode_e             mode;
    mode_e             mode_nxt;
    logic              pending;
    logic              run_pend;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              accept;
    logic              run_go;
    logic [ADDR_W-1:0] beat_ad;
    logic              beat_wc;

    always_comb begin
        accept = frame_ok && !pending && (mode == LOAD);
        // A run request waits until no write is queued or in flight.
        run_go = (run_req || run_pend) && (mode == LOAD)
               && (seq == S_IDLE) && !pending && !frame_ok;
        mode_nxt = mode;
        if (start_seen && mode == RUN) mode_nxt = LOAD;
        else if (run_go)               mode_nxt = RUN;
        beat_ad = hold_addr;
        beat_wc = 1'b0;
        unique case (seq)
            D_L: begin
                beat_ad = ADDR_W'(hold_data[HALF-1:0]);
                beat_wc = 1'b1;
            end
            D_U: begin
                beat_ad = ADDR_W'(hold_data[DATA_W-1:HALF]);
                beat_wc = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode             <= LOAD;
            cpu_rst          <= 1'b1;
            loading          <= 1'b1;
            seq              <= S_IDLE;
            pending          <= 1'b0;
            run_pend         <= 1'b0;
            hold_addr        <= '0;
            hold_data        <= '0;
            frame_count      <= '0;
            frame_err        <= 1'b0;
            mem.addr_data    <= '0;
            mem.read_write   <= 1'b0;
            mem.write_commit <= 1'b0;
        end else begin
            mode      <= mode_nxt;
            cpu_rst   <= (mode_nxt == LOAD);
            loading   <= (mode_nxt == LOAD);
            frame_err <= frame_bad || (frame_ok && !accept);

            if (run_go)
                run_pend <= 1'b0;
            else if (run_req && mode == LOAD)
                run_pend <= 1'b1;

            if (accept) begin
                hold_addr   <= p_addr;
                hold_data   <= p_data;
                pending     <= 1'b1;
                frame_count <= frame_count + 8'd1;
                seq         <= A_L;
            end else begin
                unique case (seq)
                    S_IDLE: ;
                    A_L:    seq <= D_L;
                    D_L:    seq <= A_U;
                    A_U:    seq <= D_U;
                    D_U: begin
                        seq     <= S_IDLE;
                        pending <= 1'b0;
                    end
                    default: seq <= S_IDLE;
                endcase
            end

            if (mode_nxt == RUN) begin
                mem.addr_data    <= cpu.addr_data;
                mem.read_write   <= cpu.read_write;
                mem.write_commit <= cpu.write_commit;
            end else if (seq != S_IDLE) begin
                mem.addr_data    <= beat_ad;
                mem.read_write   <= 1'b1;
                mem.write_commit <= beat_wc;
            end else begin
                mem.addr_data    <= '0;
                mem.read_write   <= 1'b0;
                mem.write_commit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader_arb.sv
// Directed and randomized bench for uart_mem_loader_arb with a frame-level model.
module tb_uart_mem_loader_arb;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam int NPAY = CS ? 5 : 4;

    typedef struct packed {
        logic [9:0] ad;
        logic       rw;
        logic       wc;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cpu_rst;
    logic       loading;
    logic [7:0] frame_count;
    logic       frame_err;

    uart_mem_loader_arb_if #(.ADDR_W(10)) cpu_bus ();
    uart_mem_loader_arb_if #(.ADDR_W(10)) mem_bus ();

    uart_mem_loader_arb dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cpu         (cpu_bus),
        .mem         (mem_bus),
        .cpu_rst     (cpu_rst),
        .loading     (loading),
        .frame_count (frame_count),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    errs_seen = 0;
    beat_t beats [$];

    always @(negedge clk) begin
        if (!rst && loading && mem_bus.read_write)
            beats.push_back({mem_bus.addr_data,
                             mem_bus.read_write,
                             mem_bus.write_commit});
        if (!rst && frame_err) errs_seen++;
    end

    // Frame-level reference state
    int         exp_fc;
    int         exp_err;
    bit         exp_run;
    bit         in_frame;
    logic [7:0] pay [$];
    beat_t      exp_q [$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    function automatic int w_addr(input int b0, input int b1);
        return (b0 % 4) * 256 + b1;
    endfunction

    function automatic int w_data(input int b2, input int b3);
        return b2 * 16 + b3 % 16;
    endfunction

    function automatic beat_t mk(input int ad, input bit wc);
        beat_t b;
        b.ad = 10'(ad);
        b.rw = 1'b1;
        b.wc = wc;
        return b;
    endfunction

    function automatic logic [11:0] mem_now();
        return {mem_bus.addr_data, mem_bus.read_write,
                mem_bus.write_commit};
    endfunction

    task automatic send_body(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input bit bad_cs);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        if (CS) send_byte((b0 ^ b1 ^ b2 ^ b3) ^ {7'd0, bad_cs});
        send_byte(8'hAA);
    endtask

    // Called right after the STOP strobe; walks the four beats cycle by cycle.
    task automatic expect_write(input string tag, input int a, input int d);
        tick(1);
        chk({tag, "_AL"}, mem_now(), mk(a, 1'b0));
        tick(1);
        chk({tag, "_DL"}, mem_now(), mk(d % 64, 1'b1));
        tick(1);
        chk({tag, "_AU"}, mem_now(), mk(a, 1'b0));
        tick(1);
        chk({tag, "_DU"}, mem_now(), mk(d / 64, 1'b1));
        tick(1);
        chk({tag, "_idle"}, mem_now(), 12'h000);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h55) exp_run = 1'b0;
        if (!in_frame) begin
            if (b == 8'h55) begin
                in_frame = 1'b1;
                pay.delete();
            end else if (b == 8'h5A) begin
                exp_run = 1'b1;
            end
        end else if (pay.size() < NPAY) begin
            if (b == 8'h55) pay.delete();
            else if (b == 8'hAA) begin
                exp_err++;
                in_frame = 1'b0;
            end else pay.push_back(b);
        end else begin
            in_frame = 1'b0;
            if (b == 8'hAA
                && (!CS || pay[NPAY-1] == (pay[0] ^ pay[1] ^ pay[2] ^ pay[3]))
                && !exp_run) begin
                int a;
                int d;
                a = w_addr(pay[0], pay[1]);
                d = w_data(pay[2], pay[3]);
                exp_fc = (exp_fc + 1) % 256;
                exp_q.push_back(mk(a, 1'b0));
                exp_q.push_back(mk(d % 64, 1'b1));
                exp_q.push_back(mk(a, 1'b0));
                exp_q.push_back(mk(d / 64, 1'b1));
            end else begin
                exp_err++;
            end
        end
    endtask

    initial begin
        int n0;
        int e0;
        logic [7:0] tok [$];
        logic [7:0] r;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_bus.addr_data    = '0;
        cpu_bus.read_write   = 1'b0;
        cpu_bus.write_commit = 1'b0;
        tick(3);
        rst = 1'b0;

        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_loading", loading, 1);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_mem", mem_now(), 12'h000);

        // Basic load
        send_byte(8'h55);
        send_body(8'h01, 8'h23, 8'hAB, 8'h0C, 1'b0);
        chk("t1_no_err", frame_err, 0);
        expect_write("t1", w_addr(8'h01, 8'h23), w_data(8'hAB, 8'h0C));
        chk("t1_count", frame_count, 1);
        chk("t1_cpu_rst", cpu_rst, 1);

        // Short frame
        e0 = errs_seen;
        n0 = beats.size();
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'hFF);
        send_byte(8'hAA);
        chk("t2_err_hi", frame_err, 1);
        tick(1);
        chk("t2_err_lo", frame_err, 0);
        tick(8);
        chk("t2_err_once", errs_seen - e0, 1);
        chk("t2_no_beats", beats.size() - n0, 0);
        chk("t2_count", frame_count, 1);

        // Release CPU, port follows the CPU bus one cycle later
        send_byte(8'h5A);
        chk("t3_cpu_rst", cpu_rst, 0);
        chk("t3_loading", loading, 0);
        cpu_bus.addr_data  = 10'h155;
        cpu_bus.read_write = 1'b1;
        tick(1);
        chk("t3_pass1", mem_now(), {10'h155, 2'b10});
        cpu_bus.addr_data    = 10'h2AA;
        cpu_bus.write_commit = 1'b1;
        tick(1);
        chk("t3_pass2", mem_now(), {10'h2AA, 2'b11});

        // START in RUN reclaims the port immediately
        send_byte(8'h55);
        chk("t4_cpu_rst", cpu_rst, 1);
        chk("t4_loading", loading, 1);
        chk("t4_mem_zero", mem_now(), 12'h000);
        cpu_bus.addr_data    = '0;
        cpu_bus.read_write   = 1'b0;
        cpu_bus.write_commit = 1'b0;
        send_body(8'h00, 8'h05, 8'h00, 8'h07, 1'b0);
        expect_write("t4", w_addr(8'h00, 8'h05), w_data(8'h00, 8'h07));
        chk("t4_count", frame_count, 2);

        // Reset mid-sequence
        send_byte(8'h55);
        send_body(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        tick(1);
        chk("t5_AL", mem_now(), mk(w_addr(1, 2), 1'b0));
        tick(1);
        chk("t5_DL", mem_now(), mk(w_data(3, 4) % 64, 1'b1));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_mem_zero", mem_now(), 12'h000);
        chk("t5_count", frame_count, 0);
        chk("t5_cpu_rst", cpu_rst, 1);
        n0 = beats.size();
        tick(8);
        chk("t5_no_AU", beats.size() - n0, 0);

        // Corrupted checksum byte (ignored when there is no checksum)
        e0 = errs_seen;
        n0 = beats.size();
        send_byte(8'h55);
        send_body(8'h01, 8'h23, 8'hAB, 8'h0C, 1'b1);
        chk("t6_err", frame_err, CS);
        tick(8);
        chk("t6_err_cnt", errs_seen - e0, CS);
        chk("t6_beats", beats.size() - n0, CS ? 0 : 4);
        chk("t6_count", frame_count, CS ? 0 : 1);

        // Randomized token streams against the frame model
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        beats.delete();
        exp_q.delete();
        e0       = errs_seen;
        exp_fc   = 0;
        exp_err  = 0;
        exp_run  = 1'b0;
        in_frame = 1'b0;
        for (int t = 0; t < 60; t++) begin
            int kind;
            logic [7:0] x;
            tok.delete();
            kind = $urandom_range(0, 4);
            if (kind <= 1 || kind == 3) begin
                logic [7:0] p [4];
                tok.push_back(8'h55);
                for (int k = 0; k < 4; k++) begin
                    p[k] = 8'($urandom_range(0, 255));
                    tok.push_back(p[k]);
                end
                x = p[0] ^ p[1] ^ p[2] ^ p[3];
                if (CS) tok.push_back(kind == 3 ? (x ^ 8'h01) : x);
                r = 8'($urandom_range(0, 255));
                if (r == 8'hAA) r = 8'h00;
                tok.push_back((kind == 3 && !CS) ? r : 8'hAA);
            end else if (kind == 2) begin
                tok.push_back(8'h55);
                repeat ($urandom_range(0, 3))
                    tok.push_back(8'($urandom_range(0, 255)));
                tok.push_back(8'hAA);
            end else begin
                repeat ($urandom_range(1, 3)) begin
                    r = 8'($urandom_range(0, 255));
                    if (r == 8'h55 || r == 8'hAA || $urandom_range(0, 1) == 1)
                        r = 8'h5A;
                    tok.push_back(r);
                end
            end
            foreach (tok[k]) begin
                send_byte(tok[k]);
                model_byte(tok[k]);
            end
            tick(8);
            chk("rnd_count", frame_count, exp_fc);
            chk("rnd_errs", errs_seen - e0, exp_err);
            chk("rnd_loading", loading, !exp_run);
            chk("rnd_cpu_rst", cpu_rst, !exp_run);
            chk("rnd_nbeats", beats.size(), exp_q.size());
            for (int k = 0; k < beats.size() && k < exp_q.size(); k++)
                chk("rnd_beat", beats[k], exp_q[k]);
            beats.delete();
            exp_q.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
